// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA ROM scanner:
//   - default 640x480@60 timing constants (totals, sync start/end, active size)
//   - scan-controller state type {IDLE, RUN, DRAIN}
//   - ROM_LAT: read latency of the pixel ROM in clocks
//   - CNT_W: width of the h/v position counters
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int H_ACT    = 640;
   localparam int V_ACT    = 480;
   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int HS_START = 656;
   localparam int HS_END   = 751;
   localparam int VS_START = 490;
   localparam int VS_END   = 491;

   localparam int ROM_LAT  = 1;

   // Wide enough for any line/frame total up to 4095.
   localparam int CNT_W    = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Inclusive range test used for the sync pulses.
   function automatic logic in_range(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Pixel-tick divider plus horizontal/vertical position counters.
// Counters only run while i_run is high; otherwise they are held at zero so a
// new scan always starts at pixel (0,0) with a fresh divider phase.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   i_run       scan controller is in RUN or DRAIN
//   o_tick      last system clock of the current pixel
//   o_last      tick of the final pixel of the frame (H_TOT-1, V_TOT-1)
//   o_h_cnt     current column
//   o_v_cnt     current line
//   o_hs_raw    undelayed hsync (active-low)
//   o_vs_raw    undelayed vsync (active-low)
//   o_act_raw   undelayed display-enable
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int H_TOT   = H_TOTAL,
   parameter int V_TOT   = V_TOTAL,
   parameter int H_ACTV  = H_ACT,
   parameter int V_ACTV  = V_ACT,
   parameter int HS_S    = HS_START,
   parameter int HS_E    = HS_END,
   parameter int VS_S    = VS_START,
   parameter int VS_E    = VS_END
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   output logic             o_tick,
   output logic             o_last,
   output logic [CNT_W-1:0] o_h_cnt,
   output logic [CNT_W-1:0] o_v_cnt,
   output logic             o_hs_raw,
   output logic             o_vs_raw,
   output logic             o_act_raw
);

   localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0]  H_ACT_C  = CNT_W'(H_ACTV);
   localparam logic [CNT_W-1:0]  V_ACT_C  = CNT_W'(V_ACTV);
   localparam logic [CNT_W-1:0]  HS_LO    = CNT_W'(HS_S);
   localparam logic [CNT_W-1:0]  HS_HI    = CNT_W'(HS_E);
   localparam logic [CNT_W-1:0]  VS_LO    = CNT_W'(VS_S);
   localparam logic [CNT_W-1:0]  VS_HI    = CNT_W'(VS_E);

   logic [DIV_W-1:0] r_div;
   logic [CNT_W-1:0] r_h;
   logic [CNT_W-1:0] r_v;
   logic             w_tick;
   logic             w_h_wrap;
   logic             w_v_wrap;

   assign w_tick   = i_run && (r_div == DIV_LAST);
   assign w_h_wrap = (r_h == H_LAST);
   assign w_v_wrap = (r_v == V_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= '0;
         r_h   <= '0;
         r_v   <= '0;
      end else if (!i_run) begin
         r_div <= '0;
         r_h   <= '0;
         r_v   <= '0;
      end else if (w_tick) begin
         r_div <= '0;
         if (w_h_wrap) begin
            r_h <= '0;
            r_v <= w_v_wrap ? '0 : r_v + 1'b1;
         end else begin
            r_h <= r_h + 1'b1;
         end
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign o_tick    = w_tick;
   assign o_last    = w_tick && w_h_wrap && w_v_wrap;
   assign o_h_cnt   = r_h;
   assign o_v_cnt   = r_v;
   assign o_hs_raw  = !in_range(r_h, HS_LO, HS_HI);
   assign o_vs_raw  = !in_range(r_v, VS_LO, VS_HI);
   // Counters sit at (0,0) while idle, which is inside the active area, so
   // display-enable has to be qualified with i_run.
   assign o_act_raw = i_run && (r_h < H_ACT_C) && (r_v < V_ACT_C);

endmodule

// File: rtl/vga_rom_scanner.sv
// -----------------------------------------------------------------------------
// vga_rom_scanner
// Sequencing controller for a pixel ROM driving a VGA output. Generates VGA
// timing, reads a centred IMG_W x IMG_H image window from the ROM with a
// linear address, and delays the sync/enable signals so they arrive together
// with the ROM's registered colour output.
//
// Optional feature (macro VGA_SCROLL_EN): adds x_off/y_off inputs that move
// the window; they are captured once per frame at frame start and clamped so
// the window stays inside the active area.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   enable       run scan-out while high (frame always completes)
//   x_off/y_off  window origin (VGA_SCROLL_EN only)
//   rd_ena       ROM read enable, high only inside the image window
//   addr         ROM address
//   hsync/vsync  active-low syncs, aligned with ROM colour
//   de           display enable, aligned with ROM colour
//   frame_start  one-clock pulse per frame, aligned with ROM colour
//   busy         high in RUN and DRAIN
// -----------------------------------------------------------------------------
module vga_rom_scanner
   import vga_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
   parameter int X0       = 192,
   parameter int Y0       = 112
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
`ifdef VGA_SCROLL_EN
   input  logic [9:0]       x_off,
   input  logic [9:0]       y_off,
`endif
   output logic             rd_ena,
   output logic [DEPTH-1:0] addr,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             frame_start,
   output logic             busy
);

   localparam int L_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int L_V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int L_HS_S  = H_ACTIVE + H_FP;
   localparam int L_VS_S  = V_ACTIVE + V_FP;

   localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_H);

   state_t           r_state;
   state_t           w_state_next;
   logic             w_run;
   logic             w_tick;
   logic             w_last;
   logic [CNT_W-1:0] w_h;
   logic [CNT_W-1:0] w_v;
   logic             w_hs_raw;
   logic             w_vs_raw;
   logic             w_act_raw;
   logic             w_fs_raw;
   logic [CNT_W-1:0] w_x0;
   logic [CNT_W-1:0] w_y0;
   logic             w_in_win;
   logic [DEPTH-1:0] r_acnt;
   logic             r_rd_ena;
   logic [DEPTH-1:0] r_addr;
   logic [ROM_LAT:0] r_hs_pipe;
   logic [ROM_LAT:0] r_vs_pipe;
   logic [ROM_LAT:0] r_de_pipe;
   logic [ROM_LAT:0] r_fs_pipe;

   vga_timing_gen #(
      .CLK_DIV (CLK_DIV),
      .H_TOT   (L_H_TOT),
      .V_TOT   (L_V_TOT),
      .H_ACTV  (H_ACTIVE),
      .V_ACTV  (V_ACTIVE),
      .HS_S    (L_HS_S),
      .HS_E    (L_HS_S + H_SYNC - 1),
      .VS_S    (L_VS_S),
      .VS_E    (L_VS_S + V_SYNC - 1)
   ) u_timing (
      .clk       (clk),
      .rst       (rst),
      .i_run     (w_run),
      .o_tick    (w_tick),
      .o_last    (w_last),
      .o_h_cnt   (w_h),
      .o_v_cnt   (w_v),
      .o_hs_raw  (w_hs_raw),
      .o_vs_raw  (w_vs_raw),
      .o_act_raw (w_act_raw)
   );

   // ---------------- scan controller ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (enable) w_state_next = RUN;
         RUN:     if (!enable) w_state_next = DRAIN;
         // Re-enable during drain resumes without touching the counters.
         DRAIN:   if (enable) w_state_next = RUN;
                  else if (w_last) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   assign w_run    = (r_state != IDLE);
   assign busy     = w_run;
   assign w_fs_raw = w_tick && (w_h == '0) && (w_v == '0);

   // ---------------- window origin ----------------
`ifdef VGA_SCROLL_EN
   localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_ACTIVE - IMG_W);
   localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_ACTIVE - IMG_H);

   function automatic logic [CNT_W-1:0] clamp_off(input logic [9:0]       off,
                                                  input logic [CNT_W-1:0] lim);
      logic [CNT_W-1:0] v;
      v = CNT_W'(off);
      return (v > lim) ? lim : v;
   endfunction

   logic [CNT_W-1:0] r_x0;
   logic [CNT_W-1:0] r_y0;

   // Captured only at the frame-start tick so a frame never tears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x0 <= CNT_W'(X0);
         r_y0 <= CNT_W'(Y0);
      end else if (w_fs_raw) begin
         r_x0 <= clamp_off(x_off, X_MAX);
         r_y0 <= clamp_off(y_off, Y_MAX);
      end
   end

   assign w_x0 = r_x0;
   assign w_y0 = r_y0;
`else
   assign w_x0 = CNT_W'(X0);
   assign w_y0 = CNT_W'(Y0);
`endif

   assign w_in_win = w_run
                     && (w_h >= w_x0) && (w_h < w_x0 + IMG_W_C)
                     && (w_v >= w_y0) && (w_v < w_y0 + IMG_H_C);

   // Raster order makes the window address a plain running count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acnt <= '0;
      end else if (!w_run) begin
         r_acnt <= '0;
      end else if (w_tick) begin
         if (w_last)        r_acnt <= '0;
         else if (w_in_win) r_acnt <= r_acnt + 1'b1;
      end
   end

   // ---------------- ROM request stage ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ena <= 1'b0;
         r_addr   <= '0;
      end else begin
         r_rd_ena <= w_in_win;
         r_addr   <= r_acnt;
      end
   end

   assign rd_ena = r_rd_ena;
   assign addr   = r_addr;

   // ---------------- sync delay: request stage + ROM latency ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs_pipe <= '1;
         r_vs_pipe <= '1;
         r_de_pipe <= '0;
         r_fs_pipe <= '0;
      end else begin
         r_hs_pipe <= {r_hs_pipe[ROM_LAT-1:0], w_hs_raw};
         r_vs_pipe <= {r_vs_pipe[ROM_LAT-1:0], w_vs_raw};
         r_de_pipe <= {r_de_pipe[ROM_LAT-1:0], w_act_raw};
         r_fs_pipe <= {r_fs_pipe[ROM_LAT-1:0], w_fs_raw};
      end
   end

   assign hsync       = r_hs_pipe[ROM_LAT];
   assign vsync       = r_vs_pipe[ROM_LAT];
   assign de          = r_de_pipe[ROM_LAT];
   assign frame_start = r_fs_pipe[ROM_LAT];

endmodule
